marlann_smem_responder: RTL and testbench

Responder/slave end of the sequencer's instruction-memory (smem) fetch interface. Serves 32-bit instruction fetches out of a single-port, 16-bit-wide code SRAM by reading two consecutive halfwords. Arbitrates the SRAM between the sequencer and a host load port (SPI/bus loader) that writes and reads 16-bit halfwords. Sits between marlann_sequencer and the code SRAM macro.

---
 rtl/marlann_smem_responder.sv | 147 ++++++++++++++
 tb/tb_marlann_smem_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/marlann_smem_responder.sv
// Responder end of the sequencer instruction-fetch port: assembles 32-bit fetches from a
// 16-bit single-port code SRAM and shares that SRAM round-robin with a host load port.
module marlann_smem_responder #(
  parameter int ADDR_BITS = 16,
  parameter bit SEQ_FIRST = 1'b1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 smem_valid,
  output logic                 smem_ready,
  input  logic [15:0]          smem_addr,
  output logic [31:0]          smem_data,
  input  logic                 host_valid,
  output logic                 host_ready,
  input  logic                 host_write,
  input  logic [15:0]          host_addr,
  input  logic [15:0]          host_wdata,
  output logic [15:0]          host_rdata,
  output logic                 ram_en,
  output logic                 ram_wen,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [15:0]          ram_wdata,
  input  logic [15:0]          ram_rdata
);

  typedef enum logic [2:0] {
    IDLE, SEQ_HI, SEQ_CAP, SEQ_ACK, HOST_CAP, HOST_ACK
  } state_t;

  state_t      state_q, state_d;
  logic        last_seq_q, last_seq_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] lo_q, lo_d;
  logic [31:0] smem_data_q, smem_data_d;
  logic        smem_ready_q, smem_ready_d;
  logic        host_ready_q, host_ready_d;
  logic [15:0] host_rdata_q, host_rdata_d;
  logic        host_wr_q, host_wr_d;

  logic        grant_seq, grant_host;
  logic [15:0] addr_inc;
  logic        ram_en_c, ram_wen_c;
  logic [15:0] ram_addr_c, ram_wdata_c;

  // When both request, the side that did not win last time gets the SRAM.
  assign grant_seq  = smem_valid && (!host_valid || !last_seq_q);
  assign grant_host = host_valid && !grant_seq;
  assign addr_inc   = addr_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    last_seq_d   = last_seq_q;
    addr_d       = addr_q;
    lo_d         = lo_q;
    smem_data_d  = smem_data_q;
    smem_ready_d = 1'b0;
    host_ready_d = 1'b0;
    host_rdata_d = host_rdata_q;
    host_wr_d    = host_wr_q;
    ram_en_c     = 1'b0;
    ram_wen_c    = 1'b0;
    ram_addr_c   = 16'd0;
    ram_wdata_c  = 16'd0;
    case (state_q)
      IDLE: begin
        if (grant_seq) begin
          ram_en_c   = 1'b1;
          ram_addr_c = smem_addr;
          addr_d     = smem_addr;
          last_seq_d = 1'b1;
          state_d    = SEQ_HI;
        end else if (grant_host) begin
          ram_en_c    = 1'b1;
          ram_wen_c   = host_write;
          ram_addr_c  = host_addr;
          ram_wdata_c = host_wdata;
          host_wr_d   = host_write;
          last_seq_d  = 1'b0;
          state_d     = HOST_CAP;
        end
      end
      SEQ_HI: begin
        ram_en_c   = 1'b1;
        ram_addr_c = addr_inc;
        // A dropped valid means the sequencer restarted; the fetch is abandoned silently.
        if (!smem_valid) begin
          state_d = IDLE;
        end else begin
          lo_d    = ram_rdata;
          state_d = SEQ_CAP;
        end
      end
      SEQ_CAP: begin
        if (!smem_valid) begin
          state_d = IDLE;
        end else begin
          smem_data_d  = {ram_rdata, lo_q};
          smem_ready_d = 1'b1;
          state_d      = SEQ_ACK;
        end
      end
      SEQ_ACK: state_d = IDLE;
      HOST_CAP: begin
        host_ready_d = 1'b1;
        if (!host_wr_q) host_rdata_d = ram_rdata;
        state_d = HOST_ACK;
      end
      HOST_ACK: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_seq_q   <= !SEQ_FIRST;
      addr_q       <= 16'd0;
      lo_q         <= 16'd0;
      smem_data_q  <= 32'd0;
      smem_ready_q <= 1'b0;
      host_ready_q <= 1'b0;
      host_rdata_q <= 16'd0;
      host_wr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_seq_q   <= last_seq_d;
      addr_q       <= addr_d;
      lo_q         <= lo_d;
      smem_data_q  <= smem_data_d;
      smem_ready_q <= smem_ready_d;
      host_ready_q <= host_ready_d;
      host_rdata_q <= host_rdata_d;
      host_wr_q    <= host_wr_d;
    end
  end

  // SRAM controls are combinational from IDLE inputs, so they are gated off while in reset.
  assign ram_en     = ram_en_c & resetn;
  assign ram_wen    = ram_wen_c & resetn;
  assign ram_addr   = resetn ? ram_addr_c[ADDR_BITS-1:0] : '0;
  assign ram_wdata  = resetn ? ram_wdata_c : 16'd0;
  assign smem_ready = smem_ready_q;
  assign smem_data  = smem_data_q;
  assign host_ready = host_ready_q;
  assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_marlann_smem_responder.sv
// Directed bench for marlann_smem_responder with a behavioural code SRAM.
module tb_marlann_smem_responder;

  logic        clock = 1'b0;
  logic        resetn;
  logic        smem_valid, smem_ready;
  logic [15:0] smem_addr;
  logic [31:0] smem_data;
  logic        host_valid, host_ready, host_write;
  logic [15:0] host_addr, host_wdata, host_rdata;
  logic        ram_en, ram_wen;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = 16'd0, pl_data = 16'd0;

  always #5 clock = ~clock;

  marlann_smem_responder #(.ADDR_BITS(16), .SEQ_FIRST(1'b1)) dut (
    .clock(clock), .resetn(resetn),
    .smem_valid(smem_valid), .smem_ready(smem_ready), .smem_addr(smem_addr), .smem_data(smem_data),
    .host_valid(host_valid), .host_ready(host_ready), .host_write(host_write),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Synchronous single-port SRAM; read data appears the cycle after the enable.
  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_en) begin
      if (ram_wen) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // Counts cycles from the accept cycle to the ready pulse, bounded at 20.
  task automatic wait_ready(input bit is_seq, input string tag, input int exp_lat);
    int n = 0;
    while ((is_seq ? smem_ready : host_ready) !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic fetch(input logic [15:0] a, input logic [31:0] exp, input string tag);
    smem_valid = 1'b1; smem_addr = a;
    #1;
    check({tag, "_ram_addr"}, ram_addr, a);
    wait_ready(1'b1, tag, 3);
    check({tag, "_data"}, smem_data, exp);
    smem_valid = 1'b0;
    tick();
    check({tag, "_ready_1cyc"}, smem_ready, 1'b0);
    check({tag, "_data_hold"}, smem_data, exp);
  endtask

  task automatic host_op(input bit wr, input logic [15:0] a, input logic [15:0] wd, input string tag);
    host_valid = 1'b1; host_write = wr; host_addr = a; host_wdata = wd;
    #1;
    check({tag, "_ram_en"}, ram_en, 1'b1);
    check({tag, "_ram_wen"}, ram_wen, wr);
    check({tag, "_ram_addr"}, ram_addr, a);
    wait_ready(1'b0, tag, 2);
    host_valid = 1'b0; host_write = 1'b0;
    tick();
    check({tag, "_ready_1cyc"}, host_ready, 1'b0);
  endtask

  initial begin
    int who [4];
    int got;
    int cyc;

    resetn = 1'b0;
    smem_valid = 1'b1; smem_addr = 16'h1234;
    host_valid = 1'b0; host_write = 1'b0; host_addr = 16'd0; host_wdata = 16'd0;
    #2;
    check("rst_smem_ready", smem_ready, 1'b0);
    check("rst_smem_data", smem_data, 32'd0);
    check("rst_host_ready", host_ready, 1'b0);
    check("rst_host_rdata", host_rdata, 16'd0);
    check("rst_ram_en_forced", ram_en, 1'b0);
    check("rst_ram_wen", ram_wen, 1'b0);
    check("rst_ram_addr", ram_addr, 16'd0);
    check("rst_ram_wdata", ram_wdata, 16'd0);
    smem_valid = 1'b0; smem_addr = 16'd0;

    preload(16'h0010, 16'h1234);
    preload(16'h0011, 16'hABCD);
    preload(16'hFFFF, 16'h0001);
    preload(16'h0000, 16'h0002);
    preload(16'h0040, 16'h4444);
    preload(16'h0041, 16'h5555);
    preload(16'h0030, 16'h3030);
    preload(16'h0031, 16'h3131);
    resetn = 1'b1;
    tick();

    fetch(16'h0010, 32'hABCD1234, "fetch10");

    host_op(1'b1, 16'h0020, 16'h5A5A, "hwrite");
    check("hwrite_mem", mem[16'h0020], 16'h5A5A);
    host_op(1'b0, 16'h0020, 16'h0000, "hread");
    check("hread_rdata", host_rdata, 16'h5A5A);

    fetch(16'hFFFF, 32'h00020001, "wrap");

    // Abort: valid dropped in SEQ_HI, new fetch three cycles after the first accept.
    smem_valid = 1'b1; smem_addr = 16'h0010;
    tick();
    smem_valid = 1'b0;
    check("abort_t1_ready", smem_ready, 1'b0);
    tick();
    check("abort_t2_ready", smem_ready, 1'b0);
    check("abort_data_held", smem_data, 32'h00020001);
    tick();
    check("abort_t3_ready", smem_ready, 1'b0);
    fetch(16'h0040, 32'h55554444, "after_abort");

    // Arbitration from a fresh reset: simultaneous requests, both held.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    smem_valid = 1'b1; smem_addr = 16'h0030;
    host_valid = 1'b1; host_write = 1'b0; host_addr = 16'h0011;
    got = 0; cyc = 0;
    while (got < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (smem_ready === 1'b1 && got < 4) begin who[got] = 1; got++; end
      if (host_ready === 1'b1 && got < 4) begin who[got] = 2; got++; end
    end
    smem_valid = 1'b0; host_valid = 1'b0;
    check("arb_pulses", got, 4);
    check("arb_first_seq", who[0], 1);
    check("arb_second_host", who[1], 2);
    check("arb_third_seq", who[2], 1);
    check("arb_fourth_host", who[3], 2);
    check("arb_seq_data", smem_data, 32'h31313030);
    check("arb_host_rdata", host_rdata, 16'hABCD);
    tick();
    tick();

    // Reset asserted during SEQ_CAP.
    smem_valid = 1'b1; smem_addr = 16'h0010;
    tick();
    tick();
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_smem_data", smem_data, 32'd0);
    check("midrst_host_rdata", host_rdata, 16'd0);
    check("midrst_ram_en", ram_en, 1'b0);
    smem_valid = 1'b0;
    tick();
    check("midrst_no_ready", smem_ready, 1'b0);
    tick();
    check("midrst_no_ready2", smem_ready, 1'b0);
    resetn = 1'b1;
    tick();
    fetch(16'h0010, 32'hABCD1234, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
